led_uart_out: RTL
=================

Name: led_uart_out

Overview:
- Output peripheral directly downstream of the stack CPU's OUT instruction.
- Consumes the CPU's LEDS byte and its Lr strobe. Buffers each written byte in a small FIFO, then serialises it as 8N1 UART on a single tx pin.
- Lets test programs stream bytes off-chip instead of only lighting LEDs.
- Also mirrors the most recent accepted byte onto a parallel led output.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (legal range 2..65535).
- DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 entries (default 16).

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- LEDS  input  8  byte from the CPU OUT instruction.
- Lr  input  1  CPU output strobe. Level signal that may stay high for several cycles.
- led  output  8  last byte accepted into the FIFO.
- tx  output  1  UART serial out, idle high.
- busy  output  1  high while a frame (start..stop) is on tx.
- full  output  1  FIFO full.
- empty  output  1  FIFO empty.
- level  output  DEPTH_LOG2+1  current FIFO occupancy.
- overflow  output  1  sticky: a byte was dropped.

Behaviour:
- Reset (rst_n low, async):
  - tx=1, busy=0, led=0, level=0, empty=1, full=0, overflow=0.
  - FIFO pointers=0, FSM=IDLE, strobe history register=0.
  - Reset mid-frame aborts the frame; tx returns high immediately (async).
  - Queued bytes are discarded.
- Capture:
  - Register Lr into lr_d each clock.
  - A write request occurs on the edge where Lr=1 and lr_d=0 (rising edge only).
  - LEDS is sampled on that same edge.
  - Lr held high for N cycles yields exactly one write.
  - Lr must return low for at least one cycle between writes.
- FIFO write:
  - If not full, or a pop occurs in the same cycle: store LEDS at the write pointer, advance the pointer, load led<=LEDS.
  - Otherwise drop the byte, set overflow=1, leave led unchanged. overflow clears only on reset.
- Pointers: DEPTH_LOG2+1 bits wide; wrap naturally modulo 2**(DEPTH_LOG2+1).
  - full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
  - level = wptr - rptr.
  - Simultaneous write and pop leaves level unchanged.
- Transmit FSM states, with a bit timer counting 0..CLKS_PER_BIT-1 and a 3-bit bit index:
  - IDLE: tx=1, busy=0. If !empty: pop a byte into shift register, tx<=0, busy<=1, timer<=0, go START.
  - START: after CLKS_PER_BIT cycles, tx<=shift[0], idx<=0, go DATA.
  - DATA: every CLKS_PER_BIT cycles shift right, tx<=next bit (LSB first). After bit 7 completes, tx<=1, go STOP.
  - STOP: after CLKS_PER_BIT cycles:
    - if !empty, pop and go START directly with tx<=0 (no idle gap);
    - else go IDLE, busy<=0.
- Latency: write edge at cycle N, level=1 visible after N. If IDLE, the pop happens at edge N+1 and tx falls at N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- The FIFO holds bytes, not frames. A byte being shifted no longer counts in level, so DEPTH bytes plus one in flight can be outstanding.
- Simultaneous write to an empty FIFO and IDLE check: the pop uses the registered empty. The byte is popped the following cycle.

Test Plan (CLKS_PER_BIT=4, DEPTH_LOG2=2):
- Reset release, no strobe → tx=1, busy=0, empty=1, level=0, led=0 for 100 cycles.
- LEDS=8'hA5, Lr high 3 cycles → led=A5, level pulses to 1 then 0. tx shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. busy high exactly 40 cycles.
- Lr held high 20 cycles while LEDS changes 11→22 → only 8'h11 transmitted, level never exceeds 1.
- Six strobes 8'h01..8'h06, one per 3 cycles, during first frame:
  - 8'h01 in flight, four queue, full=1;
  - 8'h06 is dropped, overflow=1;
  - five frames 01..05 are sent back-to-back with no idle gap.
- Pulse rst_n low mid-DATA with 2 bytes queued → tx=1, busy=0, level=0, overflow=0 asynchronously. No further frames after release.
- With FIFO full, strobe coincides with STOP→START pop → byte accepted, overflow stays 0, level stays 4.

Source files
------------

// File: rtl/led_uart_out_if.sv
// Bundle between the CPU OUT port and the led/UART output peripheral.
//   LEDS, Lr          : byte and write strobe from the CPU
//   led               : last byte accepted into the FIFO
//   tx, busy          : UART serial line (idle high) and frame-in-progress flag
//   full, empty, level: FIFO status
//   overflow          : sticky dropped-byte flag
// master = CPU side, slave = peripheral side.
interface led_uart_out_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          LEDS;
    logic                Lr;
    logic [7:0]          led;
    logic                tx;
    logic                busy;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] level;
    logic                overflow;

    modport master (
        output LEDS, Lr,
        input  led, tx, busy, full, empty, level, overflow
    );

    modport slave (
        input  LEDS, Lr,
        output led, tx, busy, full, empty, level, overflow
    );
endinterface

// File: rtl/led_uart_out.sv
// Output peripheral behind the CPU OUT instruction. Each rising edge of Lr
// captures LEDS into a FIFO and mirrors it on led; the FIFO is drained as
// 8N1 UART frames on tx, LSB first, back-to-back when bytes are waiting.
// Ports:
//   clk   : system clock, posedge
//   rst_n : asynchronous active-low reset
//   bus   : led_uart_out_if slave (LEDS/Lr in, led/tx/busy/status out)
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) on tx
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); chains straight into START if a byte is waiting
module led_uart_out #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    led_uart_out_if.slave bus
);
    localparam int          DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [15:0] BIT_TC = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state;
    logic                lr_d;
    logic [DEPTH_LOG2:0] wptr;
    logic [DEPTH_LOG2:0] rptr;
    logic [7:0]          mem [DEPTH];
    logic [15:0]         timer;
    logic [2:0]          idx;
    logic [7:0]          shift;
    logic                tx_r;
    logic                busy_r;
    logic [7:0]          led_r;
    logic                overflow_r;

    logic wr_req;
    logic wr_ok;
    logic pop;
    logic full_w;
    logic empty_w;
    logic timer_tc;

    assign empty_w  = (wptr == rptr);
    assign full_w   = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                      (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
    assign timer_tc = (timer == BIT_TC);
    assign wr_req   = bus.Lr && !lr_d;

    // Pops are decided from the registered pointers only, so a byte written
    // into an empty FIFO is picked up one cycle later.
    assign pop   = !empty_w && ((state == IDLE) || ((state == STOP) && timer_tc));
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign wr_ok = wr_req && (!full_w || pop);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[DEPTH_LOG2-1:0]] <= bus.LEDS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lr_d       <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            led_r      <= 8'h00;
            overflow_r <= 1'b0;
        end else begin
            lr_d <= bus.Lr;
            if (wr_ok) begin
                wptr  <= wptr + 1'b1;
                led_r <= bus.LEDS;
            end else if (wr_req) begin
                overflow_r <= 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            timer  <= 16'd0;
            idx    <= 3'd0;
            shift  <= 8'h00;
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                    if (pop) begin
                        shift  <= mem[rptr[DEPTH_LOG2-1:0]];
                        tx_r   <= 1'b0;
                        busy_r <= 1'b1;
                        timer  <= 16'd0;
                        state  <= START;
                    end
                end
                START: begin
                    if (timer_tc) begin
                        timer <= 16'd0;
                        tx_r  <= shift[0];
                        idx   <= 3'd0;
                        state <= DATA;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                DATA: begin
                    if (timer_tc) begin
                        timer <= 16'd0;
                        if (idx == 3'd7) begin
                            tx_r  <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift <= shift >> 1;
                            tx_r  <= shift[1];
                            idx   <= idx + 3'd1;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                STOP: begin
                    if (timer_tc) begin
                        timer <= 16'd0;
                        if (pop) begin
                            shift <= mem[rptr[DEPTH_LOG2-1:0]];
                            tx_r  <= 1'b0;
                            state <= START;
                        end else begin
                            busy_r <= 1'b0;
                            state  <= IDLE;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.led      = led_r;
    assign bus.tx       = tx_r;
    assign bus.busy     = busy_r;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.level    = wptr - rptr;
    assign bus.overflow = overflow_r;
endmodule
